// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    // Instruction fetches are always full-word accesses
    localparam logic [2:0] F3_WORD = 3'b010;

    // Request fields latched at grant and replayed on the memory port while busy
    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_access_timer.sv
// rtl/mem_port_arbiter_access_timer.sv - counts the busy cycles of one memory access
module mem_port_arbiter_access_timer #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_busy,
    output logic o_last
);

    logic [3:0] r_cnt;

    // Load the latency on grant, then count down once per busy cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= 4'(MEM_LAT);
        end else if (i_busy && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_last = i_busy && (r_cnt == 4'd1);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        flush,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_stall,
    output logic        m_en,
    output logic        m_we,
    output logic [2:0]  m_funct3,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    owner_t      r_owner;
    owner_t      w_grant_owner;
    logic        w_grant;
    logic        w_last;
    logic        w_busy;
    logic        w_fetch_active;
    mem_cmd_t    r_cmd;
    mem_cmd_t    w_cmd_nxt;
    logic [3:0]  r_starve;
    logic        r_kill;
    logic        r_if_valid;
    logic        r_d_valid;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    assign w_busy = (r_state == ARB_BUSY);

    mem_port_arbiter_access_timer #(
        .MEM_LAT (MEM_LAT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_grant),
        .i_busy (w_busy),
        .o_last (w_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration in IDLE; data wins unless the fetch side has waited STARVE_MAX grants
    always_comb begin
        w_state_nxt   = r_state;
        w_grant       = 1'b0;
        w_grant_owner = r_owner;
        case (r_state)
            ARB_IDLE: begin
                if (d_req || if_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ARB_BUSY;
                    if (d_req && !(if_req && (r_starve == 4'(STARVE_MAX)))) begin
                        w_grant_owner = OWN_DATA;
                    end else begin
                        w_grant_owner = OWN_FETCH;
                    end
                end
            end
            ARB_BUSY: begin
                if (w_last) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // Select which requester's fields are captured for the memory port
    always_comb begin
        w_cmd_nxt = '0;
        if (w_grant_owner == OWN_DATA) begin
            w_cmd_nxt = '{we: d_we, funct3: d_funct3, addr: d_addr, wdata: d_wdata};
        end else begin
            w_cmd_nxt = '{we: 1'b0, funct3: F3_WORD, addr: if_addr, wdata: 32'd0};
        end
    end

    // Latch owner and command at grant; requester inputs are ignored while busy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner <= OWN_FETCH;
            r_cmd   <= '0;
        end else if (w_grant) begin
            r_owner <= w_grant_owner;
            r_cmd   <= w_cmd_nxt;
        end
    end

    // Count data grants that overtake a waiting fetch
    always_ff @(posedge clk) begin
        if (!rst_n || !if_req) begin
            r_starve <= 4'd0;
        end else if (w_grant && (w_grant_owner == OWN_FETCH)) begin
            r_starve <= 4'd0;
        end else if (w_grant && (r_starve != 4'(STARVE_MAX))) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    assign w_fetch_active = (w_busy && (r_owner == OWN_FETCH)) ||
                            (w_grant && (w_grant_owner == OWN_FETCH));

    // A redirect during a fetch discards its response; the access itself still completes
    always_ff @(posedge clk) begin
        if (!rst_n || w_last) begin
            r_kill <= 1'b0;
        end else if (flush && w_fetch_active) begin
            r_kill <= 1'b1;
        end
    end

    // Capture read data at the end of the last busy cycle and pulse the owner's valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_if_rdata <= 32'd0;
            r_d_rdata  <= 32'd0;
        end else begin
            r_if_valid <= w_last && (r_owner == OWN_FETCH) && !r_kill && !flush;
            r_d_valid  <= w_last && (r_owner == OWN_DATA);
            if (w_last && (r_owner == OWN_FETCH)) begin
                r_if_rdata <= m_rdata;
            end
            if (w_last && (r_owner == OWN_DATA) && !r_cmd.we) begin
                r_d_rdata <= m_rdata;
            end
        end
    end

    assign if_valid = r_if_valid;
    assign if_rdata = r_if_rdata;
    assign if_stall = if_req && !r_if_valid;
    assign d_valid  = r_d_valid;
    assign d_rdata  = r_d_rdata;
    assign d_stall  = d_req && !r_d_valid;

    assign m_en     = w_busy;
    assign m_we     = w_busy && r_cmd.we;
    assign m_funct3 = r_cmd.funct3;
    assign m_addr   = r_cmd.addr;
    assign m_wdata  = r_cmd.wdata;

endmodule
